// File: rtl/min_reduce_9bit.sv
// Windowed min/argmin over 9-bit sign-magnitude samples; result registered, out_valid one cycle after the closing sample.
// While a result is held (HOLD) in_ready is low and nothing is consumed until the consumer takes the result.
module min_reduce_9bit #(
   parameter int WINDOW = 4,
   parameter int IDX_W  = $clog2(WINDOW),
   parameter int CNT_W  = $clog2(WINDOW + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [8:0]       in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [8:0]       out_min,
   output logic [IDX_W-1:0] out_idx,
   output logic [CNT_W-1:0] out_count
);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WINDOW);

   state_t           state, state_nxt;
   logic             in_xfer, out_xfer;
   logic [CNT_W-1:0] cnt_inc;

   // Sign-magnitude ordering: negatives rank by descending magnitude, so -0 sits just below +0.
   function automatic logic is_less(input logic [8:0] a, input logic [8:0] b);
      if (a[8] != b[8])
         return a[8];
      else if (!a[8])
         return a[7:0] < b[7:0];
      else
         return a[7:0] > b[7:0];
   endfunction

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;
   assign cnt_inc  = out_count + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_xfer) state_nxt = (in_last || WINDOW <= 1) ? HOLD : ACCUM;
         ACCUM:   if (in_xfer && (in_last || cnt_inc == WIN_CNT)) state_nxt = HOLD;
         HOLD:    if (out_xfer) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state != HOLD);
      out_valid = (state == HOLD);
   end

   // The running minimum registers double as the result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_min   <= 9'h000;
         out_idx   <= '0;
         out_count <= '0;
      end else if (in_xfer) begin
         if (state == IDLE) begin
            out_min   <= in_data;
            out_idx   <= '0;
            out_count <= CNT_W'(1);
         end else begin
            if (is_less(in_data, out_min)) begin
               out_min <= in_data;
               out_idx <= IDX_W'(out_count);
            end
            out_count <= cnt_inc;
         end
      end
   end

endmodule

// File: tb/tb_min_reduce_9bit.sv
// Directed and randomised checks of min_reduce_9bit with WINDOW=4.
module tb_min_reduce_9bit;

   localparam int WINDOW = 4;
   localparam int IDX_W  = $clog2(WINDOW);
   localparam int CNT_W  = $clog2(WINDOW + 1);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [8:0]       in_data = 9'h000;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [8:0]       out_min;
   logic [IDX_W-1:0] out_idx;
   logic [CNT_W-1:0] out_count;

   int total = 0;
   int fails = 0;

   min_reduce_9bit #(.WINDOW(WINDOW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_min(out_min), .out_idx(out_idx), .out_count(out_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one sample and hold it until it is accepted; returns #1 after the accepting edge.
   task automatic push(input logic [8:0] d, input logic l);
      logic rdy;
      logic acc;
      acc = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      for (int t = 0; t < 20 && !acc; t++) begin
         rdy = in_ready;
         @(posedge clk);
         acc = rdy;
      end
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("push_accepted", 32'(acc), 32'd1);
   endtask

   task automatic pop();
      logic v;
      logic done;
      done = 1'b0;
      out_ready = 1'b1;
      for (int t = 0; t < 20 && !done; t++) begin
         v = out_valid;
         @(posedge clk);
         done = v;
      end
      #1;
      out_ready = 1'b0;
      chk("pop_done", 32'(done), 32'd1);
   endtask

   task automatic chk_result(input string tag, input logic [8:0] m, input int i, input int c);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_min"},   32'(out_min),   32'(m));
      chk({tag, "_idx"},   32'(out_idx),   32'(i));
      chk({tag, "_count"}, 32'(out_count), 32'(c));
   endtask

   // Reference ordering via signed value, with -0 placed below +0.
   function automatic logic ref_less(input logic [8:0] a, input logic [8:0] b);
      int va, vb;
      va = a[8] ? -int'(a[7:0]) : int'(a[7:0]);
      vb = b[8] ? -int'(b[7:0]) : int'(b[7:0]);
      if (va != vb) return va < vb;
      return (a == 9'h100) && (b == 9'h000);
   endfunction

   initial begin : stim
      logic [8:0] held;
      logic [8:0] m, d;
      int         mi, c;
      logic       l;

      #3;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_min",   32'(out_min),   32'h000);
      chk("rst_out_idx",   32'(out_idx),   32'd0);
      chk("rst_out_count", 32'(out_count), 32'd0);
      #9 rst_n = 1'b1;

      // Basic window
      push(9'h005, 1'b0); push(9'h103, 1'b0); push(9'h007, 1'b0);
      chk("basic_not_yet", 32'(out_valid), 32'd0);
      push(9'h10A, 1'b0);
      chk_result("basic", 9'h10A, 3, 4);
      chk("basic_in_ready_low", 32'(in_ready), 32'd0);
      pop();
      chk("basic_post_valid", 32'(out_valid), 32'd0);
      chk("basic_post_ready", 32'(in_ready),  32'd1);
      chk("basic_post_min",   32'(out_min),   32'h10A);

      // Ties and signed zero
      push(9'h002, 1'b0); push(9'h002, 1'b0); push(9'h009, 1'b0); push(9'h004, 1'b0);
      chk_result("tie", 9'h002, 0, 4);
      pop();
      push(9'h000, 1'b0); push(9'h100, 1'b0); push(9'h001, 1'b0); push(9'h000, 1'b0);
      chk_result("zero", 9'h100, 1, 4);
      pop();

      // Early close, then a fresh single-sample window
      push(9'h008, 1'b0); push(9'h001, 1'b1);
      chk_result("early", 9'h001, 1, 2);
      pop();
      push(9'h003, 1'b1);
      chk_result("fresh", 9'h003, 0, 1);
      pop();

      // Backpressure with a pending input
      push(9'h0FF, 1'b0); push(9'h0FE, 1'b0); push(9'h0FD, 1'b0); push(9'h0FC, 1'b0);
      chk_result("bp", 9'h0FC, 3, 4);
      held = 9'h1AA;
      in_valid = 1'b1; in_data = held; in_last = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_min_stable", 32'(out_min), 32'h0FC);
         chk("bp_cnt_stable", 32'(out_count), 32'd4);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_released", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      push(9'h001, 1'b0); push(9'h002, 1'b0); push(9'h003, 1'b0);
      chk_result("bp_next", held, 0, 4);
      pop();

      // Asynchronous reset mid-window
      push(9'h1FF, 1'b0); push(9'h050, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_in_ready",  32'(in_ready),  32'd1);
      chk("arst_out_count", 32'(out_count), 32'd0);
      #2 rst_n = 1'b1;
      push(9'h010, 1'b0); push(9'h020, 1'b0); push(9'h030, 1'b0); push(9'h040, 1'b0);
      chk_result("arst_next", 9'h010, 0, 4);
      pop();

      // Random stream against the reference ordering
      for (int w = 0; w < 40; w++) begin
         c = 0; mi = 0; m = 9'h000;
         do begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               in_last  = 1'($urandom_range(0, 1));
               in_data  = 9'($urandom);
               @(posedge clk); #1;
            end
            in_last = 1'b0;
            d = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 3))};
            l = ($urandom_range(0, 3) == 0);
            push(d, l);
            if (c == 0 || ref_less(d, m)) begin
               m = d; mi = c;
            end
            c++;
         end while (c < WINDOW && !l);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         chk_result("rand", m, mi, c);
         pop();
      end

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule

// File: doc/min_reduce_9bit.md
Name: min_reduce_9bit

Overview:
Streaming reduction block that finds the minimum over a window of 9-bit sign-magnitude samples. Bit 8 is the sign and bits 7:0 are the magnitude. It also reports the position of the minimum within the window (argmin). It is the sequential min-side counterpart to the team's combinational max selector. It sits in the ALU/pooling path between a sample producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
WINDOW, 4, number of samples per reduction window; legal values are 2 and above.
IDX_W, $clog2(WINDOW), width of the argmin index.
CNT_W, $clog2(WINDOW+1), width of the sample-count output.

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a sample on in_data
in_ready  output  1  block can accept a sample
in_data  input  9  sample, sign-magnitude {sign, mag[7:0]}
in_last  input  1  qualifies in_data; the accepted sample closes the window early
out_valid  output  1  reduction result is available
out_ready  input  1  consumer accepts the result
out_min  output  9  minimum sample of the window, unmodified encoding
out_idx  output  IDX_W  0-based position of out_min within the window
out_count  output  CNT_W  number of samples reduced, from 1 to WINDOW

Behaviour:
- Ordering (A less than B), decided and bit-exact:
  - A negative and B positive: A is less.
  - Both positive: A is less when mag A < mag B.
  - Both negative: A is less when mag A > mag B.
  - -0 (0x100) ranks below +0 (0x000).
  - Equal codes are not "less".
- Transfers:
  - Input transfer occurs when in_valid & in_ready at a clock edge.
  - Output transfer occurs when out_valid & out_ready at a clock edge.
- States: IDLE (no sample held), ACCUM (partial window held), HOLD (result presented).
- in_ready = (state != HOLD). It is combinational from state only and does not depend on in_valid.
- out_valid = (state == HOLD). out_min, out_idx and out_count are registered.
- IDLE, on input transfer:
  - min_reg = in_data, idx_reg = 0, cnt = 1.
  - If in_last is set, or WINDOW were 1 (illegal), go to HOLD; otherwise go to ACCUM.
- ACCUM, on input transfer:
  - If in_data is less than min_reg: min_reg = in_data and idx_reg = cnt.
  - Otherwise min_reg and idx_reg are kept. On ties the earliest position wins.
  - cnt increments.
  - If the new cnt == WINDOW or in_last is set, go to HOLD.
- Result timing:
  - out_valid rises the cycle after the closing sample's transfer.
  - Outputs reflect every accepted sample including the closing one, so latency is 1 cycle.
- HOLD:
  - out_min, out_idx and out_count stay stable while out_ready is low.
  - No input is consumed in HOLD.
  - On output transfer go to IDLE; out_valid is low on the next cycle and in_ready is high.
  - Throughput: at most one window per WINDOW+1 cycles.
- No activity: in_valid low keeps the state and registers unchanged. in_last with in_valid low is ignored.
- cnt never exceeds WINDOW; the window closes at cnt == WINDOW with or without in_last.
- Reset (any time, including mid-window or in HOLD):
  - state = IDLE; the partial window is discarded.
  - out_valid = 0, out_min = 9'h000, out_idx = 0, out_count = 0, in_ready = 1.
- Outputs after a handshake: outputs other than out_valid keep their last values after the output transfer. They are don't-care while out_valid is low.
- No X-propagation: all registers are reset, and no latches are used.

Test Plan:
1. Basic window (WINDOW=4): inputs 0x005, 0x103, 0x007, 0x10A with no stalls -> one cycle after the 4th transfer, out_valid=1, out_min=0x10A, out_idx=3, out_count=4.
2. Ties and zero: inputs 0x002, 0x002, 0x009, 0x004 -> out_min=0x002, out_idx=0. Separately, inputs 0x000, 0x100, 0x001, 0x000 -> out_min=0x100, out_idx=1.
3. Early close: inputs 0x008, then 0x001 with in_last=1 -> out_min=0x001, out_idx=1, out_count=2. The next window starts fresh at idx 0.
4. Backpressure: hold out_ready=0 for 5 cycles after a result while in_valid=1 -> in_ready=0 throughout, outputs stay constant, and no sample is lost. On out_ready=1, the held sample is accepted as idx 0 of the next window.
5. Reset mid-window: accept 0x1FF and 0x050, then pulse rst_n low asynchronously between edges -> out_valid=0 and in_ready=1 immediately. Then inputs 0x010, 0x020, 0x030, 0x040 -> out_min=0x010, out_idx=0, with no influence from 0x1FF.
6. Random stream against a reference model (mixed signs, random in_valid, out_ready and in_last) -> every result matches the ordering rule, with earliest-index tie-break and correct out_count.
